// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter sharing one stb/ack single-precision FP unit among N_REQ requesters.
// Define ARB_TIMEOUT_EN to add the WAIT_Z watchdog (NaN result, sticky timeout_err, DRAIN state).
module fp_unit_arbiter #(
    parameter int N_REQ          = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [32*N_REQ-1:0] req_a,
    input  logic [N_REQ-1:0]    req_a_stb,
    output logic [N_REQ-1:0]    req_a_ack,
    input  logic [32*N_REQ-1:0] req_b,
    input  logic [N_REQ-1:0]    req_b_stb,
    output logic [N_REQ-1:0]    req_b_ack,
    output logic [31:0]         req_z,
    output logic [N_REQ-1:0]    req_z_stb,
    input  logic [N_REQ-1:0]    req_z_ack,
    output logic [31:0]         unit_a,
    output logic                unit_a_stb,
    input  logic                unit_a_ack,
    output logic [31:0]         unit_b,
    output logic                unit_b_stb,
    input  logic                unit_b_ack,
    input  logic [31:0]         unit_z,
    input  logic                unit_z_stb,
    output logic                unit_z_ack,
    output logic [ID_W-1:0]     grant_id,
    output logic                busy,
    output logic                timeout_err
);

    typedef enum logic [2:0] {
        IDLE, SEND_A, SEND_B, WAIT_Z, PUT_Z
`ifdef ARB_TIMEOUT_EN
        , DRAIN
`endif
    } state_t;

    localparam logic [N_REQ-1:0] LSB = N_REQ'(1);

    state_t            state, next_state;
    logic [ID_W-1:0]   ptr, sel, hi_sel, lo_sel;
    logic              hi_found, lo_found, found;
    logic [N_REQ-1:0]  holdoff, eligible, sel_onehot, grant_onehot;
    logic [31:0]       a_q, b_q, z_q;
    logic [31:0]       a_vec [N_REQ];
    logic [31:0]       b_vec [N_REQ];
    logic              z_seen, z_xfer, z_done;

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign a_vec[i] = req_a[32*i +: 32];
        assign b_vec[i] = req_b[32*i +: 32];
    end

    assign eligible = req_a_stb & req_b_stb & ~holdoff;

    // Lowest eligible index at or above ptr wins, else lowest below ptr (wrap-around scan).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_sel   = '0;
        lo_sel   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                if (ID_W'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_sel   = ID_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_sel   = ID_W'(i);
                end
            end
        end
    end

    assign sel          = hi_found ? hi_sel : lo_sel;
    assign found        = (hi_found || lo_found) && rst;  // no ack leaks out while held in reset
    assign sel_onehot   = LSB << sel;
    assign grant_onehot = LSB << grant_id;
    assign z_xfer       = (state == WAIT_Z) && z_seen && unit_z_stb;
    assign z_done       = (state == PUT_Z) && (|(req_z_ack & grant_onehot));

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             timed_out, timeout_hit, drain_done;

    assign timeout_hit = (state == WAIT_Z) && !z_xfer && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign drain_done  = (state == DRAIN) && unit_z_stb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt      <= '0;
            timed_out   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            wd_cnt <= (state == WAIT_Z) ? wd_cnt + 1'b1 : '0;
            if (timeout_hit) begin
                timed_out   <= 1'b1;
                timeout_err <= 1'b1;
            end else if (drain_done) begin
                timed_out <= 1'b0;
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (found)      next_state = SEND_A;
            SEND_A: if (unit_a_ack) next_state = SEND_B;
            SEND_B: if (unit_b_ack) next_state = WAIT_Z;
`ifdef ARB_TIMEOUT_EN
            WAIT_Z: if (z_xfer || timeout_hit) next_state = PUT_Z;
            PUT_Z:  if (z_done) next_state = timed_out ? DRAIN : IDLE;
            DRAIN:  if (drain_done) next_state = IDLE;
`else
            WAIT_Z: if (z_xfer) next_state = PUT_Z;
            PUT_Z:  if (z_done) next_state = IDLE;
`endif
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_a_ack  = '0;
        req_b_ack  = '0;
        req_z_stb  = '0;
        unit_a_stb = 1'b0;
        unit_b_stb = 1'b0;
        unit_z_ack = 1'b0;
        case (state)
            IDLE: if (found) begin
                req_a_ack = sel_onehot;
                req_b_ack = sel_onehot;
            end
            SEND_A: unit_a_stb = 1'b1;
            SEND_B: unit_b_stb = 1'b1;
            WAIT_Z: unit_z_ack = z_seen;
            PUT_Z:  req_z_stb  = grant_onehot;
`ifdef ARB_TIMEOUT_EN
            DRAIN:  unit_z_ack = 1'b1;
`endif
            default: ;
        endcase
    end

    assign busy   = (state != IDLE);
    assign unit_a = a_q;
    assign unit_b = b_q;
    assign req_z  = z_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            grant_id <= '0;
            a_q      <= '0;
            b_q      <= '0;
            z_q      <= '0;
            holdoff  <= '0;
            z_seen   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            holdoff <= z_done ? grant_onehot : '0;
            z_seen  <= (state == WAIT_Z) && !z_xfer && (z_seen || unit_z_stb);
            if (state == IDLE && found) begin
                a_q      <= a_vec[sel];
                b_q      <= b_vec[sel];
                grant_id <= sel;
            end
            if (z_xfer) z_q <= unit_z;
`ifdef ARB_TIMEOUT_EN
            if (timeout_hit) z_q <= 32'hFFC0_0000;
`endif
            if (z_done) ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Directed self-checking bench for fp_unit_arbiter with a table-driven multiplier stub.
// Timeout scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_fp_unit_arbiter;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [32*N-1:0]  req_a = '0, req_b = '0;
    logic [N-1:0]     req_a_stb = '0, req_b_stb = '0, req_z_ack = '0;
    logic [N-1:0]     req_a_ack, req_b_ack, req_z_stb;
    logic [31:0]      req_z, unit_a, unit_b;
    logic             unit_a_stb, unit_b_stb, unit_z_ack;
    logic             unit_a_ack = 1'b1, unit_b_ack = 1'b1;
    logic [31:0]      unit_z;
    logic             unit_z_stb;
    logic [ID_W-1:0]  grant_id;
    logic             busy, timeout_err;

    fp_unit_arbiter #(.N_REQ(N), .ID_W(ID_W), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_a_stb(req_a_stb), .req_a_ack(req_a_ack),
        .req_b(req_b), .req_b_stb(req_b_stb), .req_b_ack(req_b_ack),
        .req_z(req_z), .req_z_stb(req_z_stb), .req_z_ack(req_z_ack),
        .unit_a(unit_a), .unit_a_stb(unit_a_stb), .unit_a_ack(unit_a_ack),
        .unit_b(unit_b), .unit_b_stb(unit_b_stb), .unit_b_ack(unit_b_ack),
        .unit_z(unit_z), .unit_z_stb(unit_z_stb), .unit_z_ack(unit_z_ack),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Hand-computed single-precision products for the operand pairs used below.
    function automatic logic [31:0] mul_ref(logic [31:0] a, logic [31:0] b);
        case ({a, b})
            {32'h4040_0000, 32'h4000_0000}: return 32'h40C0_0000;  // 3.0 * 2.0
            {32'h3F00_0000, 32'h4040_0000}: return 32'h3FC0_0000;  // 0.5 * 3.0
            {32'hBF80_0000, 32'h40A0_0000}: return 32'hC0A0_0000;  // -1.0 * 5.0
            {32'h4120_0000, 32'h3E80_0000}: return 32'h4020_0000;  // 10.0 * 0.25
            {32'h3FC0_0000, 32'h3FC0_0000}: return 32'h4010_0000;  // 1.5 * 1.5
            {32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000;  // 2.0 * 2.0
            {32'h40A0_0000, 32'h3E80_0000}: return 32'h3FA0_0000;  // 5.0 * 0.25
            default:                        return a ^ b;
        endcase
    endfunction

    logic [31:0] a_cap, b_cap;
    bit          pending;
    int          lat_cnt;
    bit          unit_return = 1'b1;
    int          unit_lat = 2;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_cap <= '0; b_cap <= '0; pending <= 1'b0; lat_cnt <= 0;
            unit_z <= '0; unit_z_stb <= 1'b0;
        end else begin
            if (unit_a_stb && unit_a_ack) a_cap <= unit_a;
            if (unit_b_stb && unit_b_ack) begin
                b_cap <= unit_b; pending <= 1'b1; lat_cnt <= unit_lat;
            end else if (pending && lat_cnt > 0) begin
                lat_cnt <= lat_cnt - 1;
            end else if (pending && unit_return) begin
                pending <= 1'b0; unit_z_stb <= 1'b1; unit_z <= mul_ref(a_cap, b_cap);
            end
            if (unit_z_stb && unit_z_ack) unit_z_stb <= 1'b0;
        end
    end

    int          checks, errors;
    bit [N-1:0]  a_acked, z_acked, rereq, zack_en;
    int          ack_cnt [N];
    int          got_cnt [N];
    int          got_gid [N];
    logic [31:0] got_z [N];
    int          grant_q [$];
    int          wd_n, gq;
    bit          seen;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of client behaviour: observe at negedge, drop handshakes just after the edge.
    task automatic step();
        @(negedge clk);
        if (req_a_ack != '0) check("b_ack_with_a_ack", 32'(req_b_ack), 32'(req_a_ack));
        if (req_z_stb != '0) check("z_stb_onehot", 32'($onehot(req_z_stb)), 32'd1);
        for (int i = 0; i < N; i++) begin
            if (req_a_ack[i]) begin
                a_acked[i] = 1'b1; ack_cnt[i]++; grant_q.push_back(i);
            end
            if (req_z_stb[i] && zack_en[i] && !z_acked[i]) begin
                req_z_ack[i] = 1'b1; z_acked[i] = 1'b1;
                got_z[i] = req_z; got_gid[i] = int'(grant_id); got_cnt[i]++;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (a_acked[i]) begin
                req_a_stb[i] = 1'b0; req_b_stb[i] = 1'b0; a_acked[i] = 1'b0;
            end
            if (z_acked[i]) begin
                req_z_ack[i] = 1'b0; z_acked[i] = 1'b0;
                if (rereq[i]) begin req_a_stb[i] = 1'b1; req_b_stb[i] = 1'b1; end
            end
        end
        #1;
    endtask

    task automatic request(int i, logic [31:0] a, logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_a_stb[i] = 1'b1;
        req_b_stb[i] = 1'b1;
    endtask

    task automatic wait_quiet(string tag, int budget);
        bit done = 1'b0;
        for (int n = 0; n < budget; n++) begin
            step();
            if (!busy && req_a_stb == '0 && req_z_ack == '0) begin done = 1'b1; break; end
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_a_stb = '0; req_b_stb = '0; req_z_ack = '0;
        a_acked = '0; z_acked = '0; rereq = '0; zack_en = '1;
        unit_return = 1'b1; unit_lat = 2;
        for (int i = 0; i < N; i++) begin ack_cnt[i] = 0; got_cnt[i] = 0; got_z[i] = '0; got_gid[i] = -1; end
        grant_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: observed no finish, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        checks = 0; errors = 0;
        #2 rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_req_z", req_z, 32'd0);
        check("rst_unit_a", unit_a, 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        do_reset();

        // Single requester 0: 3.0 * 2.0
        request(0, 32'h4040_0000, 32'h4000_0000);
        wait_quiet("t1_done", 40);
        check("t1_result", got_z[0], 32'h40C0_0000);
        check("t1_grant_id", 32'(got_gid[0]), 32'd0);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_ack_pulses", 32'(ack_cnt[0]), 32'd1);

        // All four together straight after reset: grants 0,1,2,3
        do_reset();
        request(0, 32'h3F00_0000, 32'h4040_0000);
        request(1, 32'hBF80_0000, 32'h40A0_0000);
        request(2, 32'h4120_0000, 32'h3E80_0000);
        request(3, 32'h3FC0_0000, 32'h3FC0_0000);
        wait_quiet("t2_done", 150);
        check("t2_grants", 32'(grant_q.size()), 32'd4);
        for (int i = 0; i < N; i++) begin
            check("t2_order", 32'(grant_q[i]), 32'(i));
            check("t2_ack_pulses", 32'(ack_cnt[i]), 32'd1);
        end
        check("t2_z0", got_z[0], 32'h3FC0_0000);
        check("t2_z1", got_z[1], 32'hC0A0_0000);
        check("t2_z2", got_z[2], 32'h4020_0000);
        check("t2_z3", got_z[3], 32'h4010_0000);

        // Requesters 0 and 2 re-request continuously: strict alternation
        do_reset();
        request(0, 32'h4040_0000, 32'h4000_0000);
        request(2, 32'h4000_0000, 32'h4000_0000);
        rereq[0] = 1'b1; rereq[2] = 1'b1;
        for (int n = 0; n < 200 && grant_q.size() < 6; n++) step();
        rereq = '0;
        wait_quiet("t3_done", 100);
        for (int k = 0; k < 6; k++) check("t3_alternate", 32'(grant_q[k]), 32'((k % 2) * 2));
        check("t3_z0", got_z[0], 32'h40C0_0000);
        check("t3_z2", got_z[2], 32'h4080_0000);

        // Back-pressure on requester 1 for 20 cycles while requester 0 waits
        do_reset();
        zack_en[1] = 1'b0;
        request(1, 32'h4000_0000, 32'h4000_0000);
        for (int n = 0; n < 40 && !req_z_stb[1]; n++) step();
        check("t4_z_stb_seen", 32'(req_z_stb), 32'b0010);
        request(0, 32'h3F00_0000, 32'h4040_0000);
        gq = grant_q.size();
        for (int k = 0; k < 20; k++) begin
            step();
            check("t4_hold_stb", 32'(req_z_stb), 32'b0010);
            check("t4_hold_z", req_z, 32'h4080_0000);
            check("t4_hold_busy", 32'(busy), 32'd1);
        end
        check("t4_no_new_grant", 32'(grant_q.size()), 32'(gq));
        zack_en[1] = 1'b1;
        wait_quiet("t4_done", 60);
        check("t4_z1", got_z[1], 32'h4080_0000);
        check("t4_z0", got_z[0], 32'h3FC0_0000);
        check("t4_second_grant", 32'(grant_q[1]), 32'd0);

        // Reset asserted during WAIT_Z: outputs clear without a clock edge
        do_reset();
        unit_lat = 10;
        request(2, 32'h4120_0000, 32'h3E80_0000);
        for (int n = 0; n < 20 && !pending; n++) step();
        step(); step();
        check("t5_pre_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_grant_id", 32'(grant_id), 32'd0);
        check("t5_unit_a", unit_a, 32'd0);
        check("t5_unit_b", unit_b, 32'd0);
        check("t5_unit_z_ack", 32'(unit_z_ack), 32'd0);
        check("t5_a_ack", 32'(req_a_ack), 32'd0);
        check("t5_z_stb", 32'(req_z_stb), 32'd0);
        do_reset();
        request(3, 32'h40A0_0000, 32'h3E80_0000);
        wait_quiet("t5_done", 60);
        check("t5_first_grant", 32'(grant_q[0]), 32'd3);
        check("t5_z3", got_z[3], 32'h3FA0_0000);
        check("t5_no_stale_z2", 32'(got_cnt[2]), 32'd0);

`ifdef ARB_TIMEOUT_EN
        // Unit never answers: NaN after 64 WAIT_Z cycles, late result drained
        do_reset();
        unit_return = 1'b0;
        request(1, 32'h4040_0000, 32'h4000_0000);
        for (int n = 0; n < 20 && !pending; n++) step();
        for (wd_n = 0; wd_n < 200 && !req_z_stb[1]; wd_n++) step();
        check("t6_wait_cycles", 32'(wd_n), 32'd64);
        check("t6_nan", req_z, 32'hFFC0_0000);
        check("t6_timeout_err", 32'(timeout_err), 32'd1);
        step();
        unit_return = 1'b1;
        wait_quiet("t6_done", 60);
        check("t6_got_nan", got_z[1], 32'hFFC0_0000);
        check("t6_single_delivery", 32'(got_cnt[1]), 32'd1);
        check("t6_late_consumed", 32'({pending, unit_z_stb}), 32'd0);
        check("t6_sticky", 32'(timeout_err), 32'd1);
`else
        check("timeout_err_tied", 32'(timeout_err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
